// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the decode-stage hazard scoreboard.
package pipe_pkg;

  // Default pipeline depth after decode: E, M, W.
  localparam int NSTAGE_DEF = 3;

  // Forward-select value meaning "take the operand from the register file".
  localparam int FWD_SRC_RF = 0;

  // Stage indices as used by the forward-select encoding and the age field.
  localparam int STG_E = 1;
  localparam int STG_M = 2;
  localparam int STG_W = 3;

  // Width of a forward select / stage index able to hold 0..nstage.
  function automatic int sel_width(input int nstage);
    return $clog2(nstage + 1);
  endfunction

  // Clamp a requested result latency into the legal range 1..nstage.
  function automatic int clamp_lat(input int lat_in, input int nstage);
    if (lat_in < 1) begin
      return 1;
    end else if (lat_in > nstage) begin
      return nstage;
    end else begin
      return lat_in;
    end
  endfunction

endpackage

// File: rtl/pipe_hazard_scoreboard_sb_entry.sv
// One scoreboard slot: tracks the youngest in-flight writer of a single register.
// age counts the post-decode stage the producer currently occupies (1..NSTAGE);
// ready says the producer's result is already on the bus of that stage.
module sb_entry
  import pipe_pkg::*;
#(
  parameter  int NSTAGE = NSTAGE_DEF,
  localparam int LW     = $clog2(NSTAGE + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc,
  input  logic [LW-1:0] alloc_lat,
  output logic          pend,
  output logic [LW-1:0] age,
  output logic          ready
);

  logic [LW-1:0] lat_q;

  // Allocation from a new issue wins over aging/retire of the older producer.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend  <= 1'b0;
      age   <= '0;
      lat_q <= '0;
    end else if (alloc) begin
      pend  <= 1'b1;
      age   <= LW'(STG_E);
      lat_q <= alloc_lat;
    end else if (pend) begin
      if (age == LW'(NSTAGE)) begin
        pend <= 1'b0;
      end else begin
        age <= age + LW'(1);
      end
    end
  end

  // Result is forwardable once the producer has reached its result stage.
  always_comb begin
    ready = pend && (age >= lat_q);
  end

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Decode-stage hazard unit: per-register in-flight writer table, operand
// forward selects, stall decision and a saturating stall-cycle counter.
// Handshake: id_valid is the decode stage's offer; nostall is the acceptance.
// An instruction moves into E exactly on edges where issue = id_valid & nostall;
// otherwise it stays in decode and a bubble enters E (no table update).
module pipe_hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter  int NREG   = 32,
  parameter  int NSTAGE = NSTAGE_DEF,
  parameter  int FWD_EN = 1,
  parameter  int CNT_W  = 32,
  localparam int RW     = $clog2(NREG),
  localparam int SW     = sel_width(NSTAGE),
  localparam int LW     = $clog2(NSTAGE + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RW-1:0]    rs,
  input  logic [RW-1:0]    rt,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic             wreg,
  input  logic [RW-1:0]    rn,
  input  logic [LW-1:0]    lat,
  output logic [SW-1:0]    fwda,
  output logic [SW-1:0]    fwdb,
  output logic             nostall,
  output logic             issue,
  output logic [CNT_W-1:0] stall_cnt
);

  logic          pend_v  [NREG];
  logic [LW-1:0] age_v   [NREG];
  logic          ready_v [NREG];

  logic [LW-1:0] lat_c;
  logic          hit_a;
  logic          hit_b;
  logic          stall_a;
  logic          stall_b;

  // Register 0 is hard-wired zero and never has a pending producer.
  assign pend_v[0]  = 1'b0;
  assign age_v[0]   = '0;
  assign ready_v[0] = 1'b0;

  // Requested latency folded into 1..NSTAGE before it is stored.
  always_comb begin
    lat_c = LW'(clamp_lat(int'(lat), NSTAGE));
  end

  for (genvar r = 1; r < NREG; r++) begin : g_ent
    sb_entry #(
      .NSTAGE (NSTAGE)
    ) u_ent (
      .clk       (clk),
      .rst       (rst),
      .alloc     (issue && wreg && (rn == RW'(r))),
      .alloc_lat (lat_c),
      .pend      (pend_v[r]),
      .age       (age_v[r]),
      .ready     (ready_v[r])
    );
  end

  // Operand lookup: a hit either forwards from the producer's stage or stalls.
  always_comb begin
    hit_a = use_rs && (rs != '0) && pend_v[rs];
    hit_b = use_rt && (rt != '0) && pend_v[rt];
    fwda  = SW'(FWD_SRC_RF);
    fwdb  = SW'(FWD_SRC_RF);
    if (FWD_EN != 0) begin
      if (hit_a && ready_v[rs]) fwda = SW'(age_v[rs]);
      if (hit_b && ready_v[rt]) fwdb = SW'(age_v[rt]);
      stall_a = hit_a && !ready_v[rs];
      stall_b = hit_b && !ready_v[rt];
    end else begin
      stall_a = hit_a;
      stall_b = hit_b;
    end
  end

  // Stall only matters when decode holds a real instruction.
  always_comb begin
    nostall = !(id_valid && (stall_a || stall_b));
    issue   = id_valid && nostall;
  end

  // Count decode cycles lost to hazards; holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (id_valid && !nostall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Directed bench for the hazard scoreboard. Three instances share one input
// set: default (forwarding on), forwarding off, and a 4-bit stall counter.
module tb_pipe_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       use_rs;
  logic       use_rt;
  logic       wreg;
  logic [4:0] rn;
  logic [1:0] lat;

  logic [1:0]  fwda0, fwdb0, fwda1, fwdb1, fwda2, fwdb2;
  logic        nostall0, nostall1, nostall2;
  logic        issue0, issue1, issue2;
  logic [31:0] stall_cnt0, stall_cnt1;
  logic [3:0]  stall_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  // Clock
  always #5 clk = ~clk;

  pipe_hazard_scoreboard u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .rs(rs), .rt(rt),
    .use_rs(use_rs), .use_rt(use_rt), .wreg(wreg), .rn(rn), .lat(lat),
    .fwda(fwda0), .fwdb(fwdb0), .nostall(nostall0), .issue(issue0),
    .stall_cnt(stall_cnt0)
  );

  pipe_hazard_scoreboard #(.FWD_EN(0)) u_nf (
    .clk(clk), .rst(rst), .id_valid(id_valid), .rs(rs), .rt(rt),
    .use_rs(use_rs), .use_rt(use_rt), .wreg(wreg), .rn(rn), .lat(lat),
    .fwda(fwda1), .fwdb(fwdb1), .nostall(nostall1), .issue(issue1),
    .stall_cnt(stall_cnt1)
  );

  pipe_hazard_scoreboard #(.CNT_W(4)) u_c4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .rs(rs), .rt(rt),
    .use_rs(use_rs), .use_rt(use_rt), .wreg(wreg), .rn(rn), .lat(lat),
    .fwda(fwda2), .fwdb(fwdb2), .nostall(nostall2), .issue(issue2),
    .stall_cnt(stall_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then drive/sample 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #3;
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic ua,
                       input logic [4:0] b, input logic ub, input logic w,
                       input logic [4:0] d, input logic [1:0] l);
    id_valid = v; rs = a; use_rs = ua; rt = b; use_rt = ub;
    wreg = w; rn = d; lat = l;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0);
  endtask

  task automatic write_reg(input logic [4:0] d, input logic [1:0] l);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, d, l);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // Reset state
    settle();
    chk("rst_fwda", fwda0, 0);
    chk("rst_fwdb", fwdb0, 0);
    chk("rst_nostall", nostall0, 1);
    chk("rst_issue_idle", issue0, 0);
    chk("rst_cnt", stall_cnt0, 0);
    id_valid = 1'b1;
    settle();
    chk("rst_issue_valid", issue0, 1);
    step();

    // 1: ALU result walks E -> M -> W -> regfile
    write_reg(5'd3, 2'd1);
    settle();
    chk("t1_issue", issue0, 1);
    step();
    drive(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 2'd1);
    settle();
    chk("t1_nostall", nostall0, 1);
    chk("t1_fwda_e", fwda0, 1);
    chk("t1_fwdb_e", fwdb0, 1);
    step(); settle();
    chk("t1_fwda_m", fwda0, 2);
    step(); settle();
    chk("t1_fwda_w", fwda0, 3);
    step(); settle();
    chk("t1_fwda_rf", fwda0, 0);
    chk("t1_cnt", stall_cnt0, 0);
    step();

    // 2: load-use on operand B stalls one cycle
    write_reg(5'd5, 2'd2);
    step();
    drive(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 2'd1);
    settle();
    chk("t2_nostall0", nostall0, 0);
    chk("t2_issue0", issue0, 0);
    chk("t2_fwdb0", fwdb0, 0);
    step(); settle();
    chk("t2_nostall1", nostall0, 1);
    chk("t2_fwdb1", fwdb0, 2);
    chk("t2_cnt", stall_cnt0, 1);
    step();

    // 3: back-to-back writers of r4, youngest (lat 2) governs
    write_reg(5'd4, 2'd1);
    step();
    write_reg(5'd4, 2'd2);
    step();
    drive(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'd1);
    settle();
    chk("t3_nostall0", nostall0, 0);
    chk("t3_fwda0", fwda0, 0);
    step(); settle();
    chk("t3_nostall1", nostall0, 1);
    chk("t3_fwda1", fwda0, 2);
    chk("t3_cnt", stall_cnt0, 2);
    step();

    // 4: r0 never tracked; unused operand never stalls; id_valid=0 never stalls
    write_reg(5'd0, 2'd1);
    step();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 2'd1);
    settle();
    chk("t4_r0_fwda", fwda0, 0);
    chk("t4_r0_nostall", nostall0, 1);
    step();
    write_reg(5'd9, 2'd3);
    step();
    drive(1'b1, 5'd9, 1'b0, 5'd9, 1'b0, 1'b0, 5'd0, 2'd1);
    settle();
    chk("t4_unused_nostall", nostall0, 1);
    chk("t4_unused_fwda", fwda0, 0);
    use_rs = 1'b1;
    settle();
    chk("t4_used_nostall", nostall0, 0);
    id_valid = 1'b0;
    settle();
    chk("t4_novalid_nostall", nostall0, 1);
    chk("t4_novalid_issue", issue0, 0);
    step();
    chk("t4_cnt", stall_cnt0, 2);

    // 5: forwarding disabled - wait for producer to retire past W
    do_reset();
    settle();
    chk("t5_rst_cnt", stall_cnt1, 0);
    write_reg(5'd3, 2'd1);
    step();
    drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'd1);
    settle();
    chk("t5_nostall_c1", nostall1, 0);
    chk("t5_dut_fwda", fwda0, 1);
    step(); settle();
    chk("t5_nostall_c2", nostall1, 0);
    step(); settle();
    chk("t5_nostall_c3", nostall1, 0);
    step(); settle();
    chk("t5_nostall_c4", nostall1, 1);
    chk("t5_fwda_c4", fwda1, 0);
    chk("t5_cnt", stall_cnt1, 3);
    step();

    // 6: reset with a stalled consumer drops the pending producer
    do_reset();
    write_reg(5'd7, 2'd3);
    step();
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'd1);
    settle();
    chk("t6_stall_c1", nostall0, 0);
    step(); settle();
    chk("t6_stall_c2", nostall0, 0);
    chk("t6_cnt_pre", stall_cnt0, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    chk("t6_post_nostall", nostall0, 1);
    chk("t6_post_fwda", fwda0, 0);
    chk("t6_post_cnt", stall_cnt0, 0);

    // 6b: self-dependent lat-3 writer gives 2 stalls per 3 cycles; 20 stalls total
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 5'd7, 2'd3);
    repeat (31) step();
    settle();
    chk("t6_sat_cnt4", stall_cnt2, 15);
    chk("t6_cnt32", stall_cnt0, 20);
    chk("t6_loop_nostall", nostall0, 0);

    idle();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
